// File: rtl/four_bits_adder.sv
// Borrow-save (signed-digit) adder: two rows of full adders per digit, carry-free
// so delay does not grow with bits. Optional single output register stage.
module four_bits_adder #(
  parameter int unsigned bits       = 64,
  parameter int unsigned REGISTERED = 0
) (
  input  logic            clk,
  input  logic            asyn_reset,
  input  logic [bits-1:0] x_plus,
  input  logic [bits-1:0] x_minus,
  input  logic [bits-1:0] y_plus,
  input  logic [bits-1:0] y_minus,
  input  logic [1:0]      cin,
  output logic [bits-1:0] z_plus,
  output logic [bits-1:0] z_minus,
  output logic [1:0]      cout
);

  logic [bits-1:0] s1, c1, c1_in;
  logic [bits-1:0] s2, c2;
  logic [bits-1:0] nx_minus, ny_minus;
  logic [bits-1:0] sum_plus, sum_minus;
  logic [1:0]      sum_cout;

  // Inverting a minus bit adds +1 per position in each row; those 2^bits-1 offsets
  // cancel against the ~s2 encoding of z_minus, leaving -1 at position 0 and +1 at
  // cout, which the ~cin[0] and ~c2[top] inversions below absorb.
  always_comb begin
    nx_minus = ~x_minus;
    ny_minus = ~y_minus;

    s1 = x_plus ^ nx_minus ^ y_plus;
    c1 = (x_plus & nx_minus) | (x_plus & y_plus) | (nx_minus & y_plus);

    c1_in = {c1[bits-2:0], cin[1]};

    s2 = s1 ^ ny_minus ^ c1_in;
    c2 = (s1 & ny_minus) | (s1 & c1_in) | (ny_minus & c1_in);

    sum_plus  = {c2[bits-2:0], ~cin[0]};
    sum_minus = ~s2;
    sum_cout  = {c1[bits-1], ~c2[bits-1]};
  end

  if (REGISTERED != 0) begin : g_reg
    always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
        z_plus  <= '0;
        z_minus <= '0;
        cout    <= '0;
      end else begin
        z_plus  <= sum_plus;
        z_minus <= sum_minus;
        cout    <= sum_cout;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ asyn_reset;

    always_comb begin
      z_plus  = sum_plus;
      z_minus = sum_minus;
      cout    = sum_cout;
    end
  end

endmodule

// File: tb/tb_four_bits_adder.sv
// Bench for four_bits_adder: 4-digit combinational instance checked exhaustively,
// 64-digit registered instance checked with random stimulus and async reset.
`timescale 1ns/1ps
module tb_four_bits_adder;

  typedef logic signed [71:0] num_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        asyn_reset;
  logic        tie0;
  logic [3:0]  xp4, xm4, yp4, ym4, zp4, zm4;
  logic [1:0]  cin4, cout4;
  logic [63:0] xp, xm, yp, ym, zp, zm;
  logic [1:0]  cin, cout;

  int checks = 0;
  int errors = 0;

  four_bits_adder #(.bits(4), .REGISTERED(0)) u_comb (
    .clk(tie0), .asyn_reset(tie0),
    .x_plus(xp4), .x_minus(xm4), .y_plus(yp4), .y_minus(ym4),
    .z_plus(zp4), .z_minus(zm4), .cin(cin4), .cout(cout4)
  );

  four_bits_adder #(.bits(64), .REGISTERED(1)) u_reg (
    .clk(clk), .asyn_reset(asyn_reset),
    .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym),
    .z_plus(zp), .z_minus(zm), .cin(cin), .cout(cout)
  );

  task automatic check(input string tag, input num_t got, input num_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Value of a borrow-save vector is simply unsigned(plus) - unsigned(minus).
  function automatic num_t bsd_val(input logic [63:0] p, input logic [63:0] m);
    return $signed({8'b0, p}) - $signed({8'b0, m});
  endfunction

  function automatic num_t digit(input logic [1:0] d);
    return num_t'(d[1]) - num_t'(d[0]);
  endfunction

  function automatic num_t total4();
    return bsd_val({60'b0, zp4}, {60'b0, zm4}) + num_t'(16) * digit(cout4);
  endfunction

  function automatic num_t total64();
    return bsd_val(zp, zm) + (num_t'(1) <<< 64) * digit(cout);
  endfunction

  function automatic num_t ref4();
    return bsd_val({60'b0, xp4}, {60'b0, xm4}) + bsd_val({60'b0, yp4}, {60'b0, ym4}) + digit(cin4);
  endfunction

  function automatic num_t ref64();
    return bsd_val(xp, xm) + bsd_val(yp, ym) + digit(cin);
  endfunction

  task automatic rand_inputs();
    int unsigned sel;
    xp  = {$urandom, $urandom};
    xm  = {$urandom, $urandom};
    yp  = {$urandom, $urandom};
    ym  = {$urandom, $urandom};
    cin = 2'($urandom);
    sel = $urandom_range(0, 7);
    if (sel == 0) begin xp = '0; xm = '0; end
    if (sel == 1) begin yp = '0; ym = '0; end
  endtask

  initial begin
    num_t exp_old, exp_new;
    tie0 = 1'b0;
    asyn_reset = 1'b1;
    {xp, xm, yp, ym, cin} = '0;
    {xp4, xm4, yp4, ym4, cin4} = '0;
    #1;
    check("rst_init", num_t'(|{zp, zm, cout}), 0);

    // Directed combinational cases
    {xp4, xm4, yp4, ym4, cin4} = {4'b0101, 4'b0000, 4'b0011, 4'b0000, 2'b00};
    #1 check("dir_8", total4(), 8);
    {xp4, xm4, yp4, ym4, cin4} = {4'b0000, 4'b1111, 4'b0000, 4'b1111, 2'b01};
    #1 check("dir_m31_total", total4(), -31);
    check("dir_m31_cout", digit(cout4), -1);
    check("dir_m31_z", bsd_val({60'b0, zp4}, {60'b0, zm4}), -15);
    {xp4, xm4, yp4, ym4, cin4} = {4'b1010, 4'b1010, 4'b1111, 4'b0000, 2'b10};
    #1 check("dir_16_total", total4(), 16);
    check("dir_16_cout", num_t'(digit(cout4) == 0 || digit(cout4) == 1), 1);

    // Exhaustive over all 2^18 combinations of the 4-digit instance
    for (int v = 0; v < (1 << 18); v++) begin
      {xp4, xm4, yp4, ym4, cin4} = 18'(v);
      #1 check("exhaustive", total4(), ref4());
    end

    check("rst_held", num_t'(|{zp, zm, cout}), 0);

    // Release reset between edges; first edge loads the current inputs
    @(negedge clk);
    rand_inputs();
    exp_old = ref64();
    #2 asyn_reset = 1'b0;
    #1 check("rst_release_hold", num_t'(|{zp, zm, cout}), 0);
    @(negedge clk);
    check("first_load", total64(), exp_old);

    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      exp_new = ref64();
      #1 check("latency_hold", total64(), exp_old);
      @(negedge clk);
      check("stream", total64(), exp_new);
      exp_old = exp_new;
    end

    // Mid-stream reset: in-flight result discarded, zero held until first edge after release
    for (int r = 0; r < 3; r++) begin
      xp = 64'hFFFF_0000_1234_5678; xm = '0; yp = 64'h0000_FFFF_0000_0001; ym = '0; cin = 2'b10;
      @(negedge clk);
      check("pre_rst_nonzero", num_t'(|{zp, zm}), 1);
      rand_inputs();
      #2 asyn_reset = 1'b1;
      #1 check("rst_immediate", num_t'(|{zp, zm, cout}), 0);
      @(negedge clk);
      check("rst_over_edge", num_t'(|{zp, zm, cout}), 0);
      rand_inputs();
      exp_new = ref64();
      #2 asyn_reset = 1'b0;
      #1 check("rst_no_stale", num_t'(|{zp, zm, cout}), 0);
      @(negedge clk);
      check("post_rst_load", total64(), exp_new);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/four_bits_adder.md
FOUR_BITS_ADDER -- requirements
Module: four_bits_adder

Interface
REQ-001 Parameter bits, default 64: digit count of each operand and sum vector; legal range >= 2.
REQ-002 Parameter REGISTERED, default 0: 0 = combinational outputs; 1 = outputs registered one cycle.
REQ-003 clk  input  1  clock; used only when REGISTERED=1.
REQ-004 asyn_reset  input  1  reset, asynchronous, active-high; used only when REGISTERED=1.
REQ-005 x_plus  input  bits  positive bit-vector of operand X.
REQ-006 x_minus  input  bits  negative bit-vector of operand X.
REQ-007 y_plus  input  bits  positive bit-vector of operand Y.
REQ-008 y_minus  input  bits  negative bit-vector of operand Y.
REQ-009 z_plus  output  bits  positive bit-vector of sum Z.
REQ-010 z_minus  output  bits  negative bit-vector of sum Z.
REQ-011 cin  input  2  carry-in digit; bit 1 = plus (weight +1), bit 0 = minus (weight -1).
REQ-012 cout  output  2  carry-out digit, weight 2^bits; bit 1 = plus, bit 0 = minus.

Function
REQ-013 Borrow-save encoding: digit i of V = V_plus[i] - V_minus[i], range {-1,0,1}; value V = sum over i of digit_i * 2^i; both bits 1 is a legal zero digit.
REQ-014 Invariant, all input combinations: val(Z) + 2^bits * (cout[1] - cout[0]) = val(X) + val(Y) + cin[1] - cin[0].
REQ-015 Carry-free structure: each z digit depends only on input digits at positions i, i-1, i-2 plus cin for the low positions.
REQ-016 No carry or borrow chain may span more than two digit positions; delay SHALL be independent of bits.
REQ-017 Implementation: two rows of full adders, one per digit position per row.
REQ-018 Row 1 at position i: inputs x_plus[i], inverted x_minus[i], y_plus[i].
REQ-019 Row 2 at position i: inputs the row-1 sum, inverted y_minus[i], the row-1 carry from position i-1.
REQ-020 The constant offsets introduced by the inverted inputs SHALL be absorbed at position 0 and at cout, so that REQ-014 holds exactly.
REQ-021 Carry-out range: cout value in {-1,0,+1}; cout = 2'b11 is permitted and equals 0.
REQ-022 Any single operand all-zero (plus and minus both 0): Z with cout satisfies REQ-014 without exception.
REQ-023 REGISTERED=0: z_plus, z_minus and cout are purely combinational; clk and asyn_reset have no effect.
REQ-024 REGISTERED=1: z_plus, z_minus and cout SHALL be captured on posedge clk; latency 1 cycle; new inputs are accepted every cycle.
REQ-025 No X-propagation from unused ports: clk and asyn_reset may be tied to 0 when REGISTERED=0.

Reset
REQ-026 REGISTERED=1: asyn_reset high SHALL immediately force z_plus, z_minus and cout to 0, independent of clk.
REQ-027 REGISTERED=1: after asyn_reset deasserts, the first posedge clk loads the sum of the current inputs.
REQ-028 asyn_reset asserted mid-stream discards the in-flight result; no stale value appears after release.
REQ-029 REGISTERED=0: no reset state exists.

Verification
REQ-030 bits=4, REGISTERED=0; x_plus=0101, y_plus=0011, all minus bits 0, cin=00 -> val(Z) + 16*cout = 8.
REQ-031 bits=4; x_minus=1111, y_minus=1111, plus bits 0, cin=01 -> total = -31; cout value -1, val(Z) = -15.
REQ-032 bits=4; x_plus=x_minus=1010, y_plus=1111, cin=10 -> total = 16; check REQ-014 and cout in {0,+1}.
REQ-033 Exhaustive run, bits=4, all 2^18 input combinations: REQ-014 holds and cout value is never +/-2.
REQ-034 bits=64, REGISTERED=1, random stimulus: outputs match the REGISTERED=0 model delayed by one clk.
REQ-035 REGISTERED=1: assert asyn_reset between clock edges while outputs are nonzero -> outputs 0 at once and held until the first edge after release.
